mem_port_arbiter: RTL and testbench

//  Shares the single main-memory port between two cache controllers (req0 = I-cache,
//  req1 = D-cache). Each controller otherwise drives MStrobe/MRW and waits on its own

---
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one main-memory port between the I-cache (req0) and
// the D-cache (req1). Round-robin grant, single memory strobe, central
// wait-state counting, and a one-cycle ready pulse back to the winner.
module mem_port_arbiter #(
    parameter int WAIT_CYCLES = 4,
    parameter int CTR_W       = $clog2(WAIT_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic req0_strobe,
    input  logic req0_rw,
    input  logic req1_strobe,
    input  logic req1_rw,
    output logic mem_strobe,
    output logic mem_rw,
    output logic mem_sel,
    output logic ready0,
    output logic ready1,
    output logic busy
);

    // A zero wait-state memory makes the WAIT state meaningless.
    generate
        if (WAIT_CYCLES < 1) begin : g_bad_wait
            $error("mem_port_arbiter: WAIT_CYCLES must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CTR_W-1:0] r_ctr;
    logic [CTR_W-1:0] w_ctr_next;
    logic             r_sel;
    logic             w_sel_next;
    logic             r_rw;
    logic             w_rw_next;
    logic             r_last;
    logic             w_last_next;
    logic [1:0]       r_cool;
    logic [1:0]       w_cool_next;

    logic [1:0]       w_strobe;
    logic [1:0]       w_rw_in;
    logic [1:0]       w_elig;
    logic [1:0]       w_ready;
    logic             w_grant;

    assign w_strobe = {req1_strobe, req0_strobe};
    assign w_rw_in  = {req1_rw, req0_rw};

    // Per-requester eligibility (a requester that just finished is blocked for
    // one IDLE cycle since its strobe may still be stale) and ready decode.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign w_elig[gi]  = w_strobe[gi] & ~r_cool[gi];
            assign w_ready[gi] = (r_state == S_DONE) && (r_sel == 1'(gi));
        end
    endgenerate

    // On a tie the requester that did not win last time gets the port.
    assign w_grant = (w_elig == 2'b11) ? ~r_last : w_elig[1];

    assign ready0  = w_ready[0];
    assign ready1  = w_ready[1];
    assign mem_rw  = r_rw;
    assign mem_sel = r_sel;

    // Next-state, datapath next values and state-decoded outputs.
    always_comb begin
        w_state_next = r_state;
        w_ctr_next   = r_ctr;
        w_sel_next   = r_sel;
        w_rw_next    = r_rw;
        w_last_next  = r_last;
        w_cool_next  = 2'b00;
        mem_strobe   = 1'b0;
        busy         = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (|w_elig) begin
                    w_sel_next   = w_grant;
                    w_rw_next    = w_rw_in[w_grant];
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_strobe   = 1'b1;
                w_ctr_next   = CTR_W'(WAIT_CYCLES - 1);
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (r_ctr == '0) begin
                    w_state_next = S_DONE;
                end else begin
                    w_ctr_next = r_ctr - CTR_W'(1);
                end
            end
            S_DONE: begin
                w_last_next         = r_sel;
                w_cool_next[r_sel]  = 1'b1;
                w_state_next        = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any access in flight immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Wait counter, latched grant, round-robin history and cooldown flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctr  <= '0;
            r_sel  <= 1'b0;
            r_rw   <= 1'b0;
            r_last <= 1'b1;
            r_cool <= 2'b00;
        end else begin
            r_ctr  <= w_ctr_next;
            r_sel  <= w_sel_next;
            r_rw   <= w_rw_next;
            r_last <= w_last_next;
            r_cool <= w_cool_next;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random requester traffic,
// checked cycle by cycle against a transaction-timeline reference model.
module tb_mem_port_arbiter;

    localparam int W = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic req0_strobe = 1'b0;
    logic req0_rw = 1'b0;
    logic req1_strobe = 1'b0;
    logic req1_rw = 1'b0;
    logic mem_strobe;
    logic mem_rw;
    logic mem_sel;
    logic ready0;
    logic ready1;
    logic busy;

    int checks = 0;
    int failures = 0;

    mem_port_arbiter #(.WAIT_CYCLES(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_strobe (req0_strobe),
        .req0_rw     (req0_rw),
        .req1_strobe (req1_strobe),
        .req1_rw     (req1_rw),
        .mem_strobe  (mem_strobe),
        .mem_rw      (mem_rw),
        .mem_sel     (mem_sel),
        .ready0      (ready0),
        .ready1      (ready1),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Reference model: one outstanding transaction described by its grant
    // cycle; every output follows from the offset to that cycle.
    int   m_cyc;
    bit   m_act;
    bit   m_sel;
    bit   m_rw;
    int   m_gt;
    int   m_done;
    bit   m_last;
    bit [1:0] done_flag;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, m_cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cyc     = 0;
        m_act     = 1'b0;
        m_sel     = 1'b0;
        m_rw      = 1'b0;
        m_gt      = 0;
        m_done    = -100;
        m_last    = 1'b1;
        done_flag = 2'b00;
    endtask

    // Apply inputs for the current cycle, advance one clock, check outputs.
    task automatic step(input bit s0, input bit rw0, input bit s1, input bit rw1);
        bit e0;
        bit e1;
        int d;
        bit xs;
        bit xb;
        bit xr;
        req0_strobe = s0;
        req0_rw     = rw0;
        req1_strobe = s1;
        req1_rw     = rw1;
        if (!m_act && m_cyc > m_done) begin
            e0 = s0 && !(m_done == m_cyc - 1 && m_last == 1'b0);
            e1 = s1 && !(m_done == m_cyc - 1 && m_last == 1'b1);
            if (e0 || e1) begin
                m_act = 1'b1;
                m_gt  = m_cyc;
                m_sel = (e0 && e1) ? !m_last : e1;
                m_rw  = m_sel ? rw1 : rw0;
            end
        end
        @(posedge clk);
        #1;
        m_cyc++;
        d  = m_cyc - m_gt;
        xs = m_act && d == 1;
        xb = m_act && d >= 1 && d <= W + 2;
        xr = m_act && d == W + 2;
        check("mem_strobe", mem_strobe, xs);
        check("busy", busy, xb);
        check("ready0", ready0, xr && !m_sel);
        check("ready1", ready1, xr && m_sel);
        if (xb) begin
            check("mem_sel", mem_sel, m_sel);
            check("mem_rw", mem_rw, m_rw);
        end
        done_flag = {xr && m_sel, xr && !m_sel};
        if (xr) begin
            m_act  = 1'b0;
            m_done = m_cyc;
            m_last = m_sel;
        end
    endtask

    // Asynchronous reset away from the clock edge; outputs must clear at once.
    task automatic do_reset();
        #2;
        reset       = 1'b0;
        req0_strobe = 1'b0;
        req1_strobe = 1'b0;
        req0_rw     = 1'b0;
        req1_rw     = 1'b0;
        #1;
        check("rst_mem_strobe", mem_strobe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready0", ready0, 1'b0);
        check("rst_ready1", ready1, 1'b0);
        check("rst_mem_sel", mem_sel, 1'b0);
        check("rst_mem_rw", mem_rw, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    bit pend  [2];
    bit stale [2];
    bit prw   [2];
    bit s     [2];
    bit rw    [2];

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        check("init_busy", busy, 1'b0);
        check("init_mem_strobe", mem_strobe, 1'b0);
        check("init_ready0", ready0, 1'b0);
        check("init_ready1", ready1, 1'b0);
        check("init_mem_sel", mem_sel, 1'b0);
        check("init_mem_rw", mem_rw, 1'b0);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_reset();

        // Single read by req0.
        for (int c = 0; c < 7; c++) step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 1'b0, 1'b0);
        $display("scenario single_read checks=%0d failures=%0d", checks, failures);

        // Tie right after reset: req0 first, then req1 write.
        do_reset();
        for (int c = 0; c < 14; c++) step(c <= 6, 1'b0, 1'b1, 1'b1);
        for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 1'b0, 1'b0);
        $display("scenario tie_after_reset checks=%0d failures=%0d", checks, failures);

        // Both held continuously: four alternating grants.
        for (int c = 0; c < 28; c++) step(1'b1, 1'b0, 1'b1, 1'b1);
        for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 1'b0, 1'b0);
        $display("scenario alternate checks=%0d failures=%0d", checks, failures);

        // Stale strobe one cycle past ready0 must not start a new access.
        for (int c = 0; c < 8; c++) step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) step(1'b0, 1'b0, 1'b0, 1'b0);
        $display("scenario stale_strobe checks=%0d failures=%0d", checks, failures);

        // Strobe dropped mid-access: ready still fires.
        for (int c = 0; c < 3; c++) step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 8; c++) step(1'b0, 1'b0, 1'b0, 1'b0);
        $display("scenario early_drop checks=%0d failures=%0d", checks, failures);

        // Random requester traffic.
        for (int i = 0; i < 2; i++) begin
            pend[i]  = 1'b0;
            stale[i] = 1'b0;
            prw[i]   = 1'b0;
        end
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (pend[i]) begin
                    if (m_act && int'(m_sel) == i) begin
                        s[i]  = ($urandom_range(0, 3) != 0);
                        rw[i] = 1'($urandom_range(0, 1));
                    end else begin
                        s[i]  = 1'b1;
                        rw[i] = prw[i];
                    end
                    if (done_flag[i]) begin
                        pend[i]  = 1'b0;
                        stale[i] = 1'b1;
                    end
                end else if (stale[i]) begin
                    s[i]     = 1'($urandom_range(0, 1));
                    rw[i]    = 1'($urandom_range(0, 1));
                    stale[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    prw[i]  = 1'($urandom_range(0, 1));
                    s[i]    = 1'b1;
                    rw[i]   = prw[i];
                end else begin
                    s[i]  = 1'b0;
                    rw[i] = 1'($urandom_range(0, 1));
                end
            end
            step(s[0], rw[0], s[1], rw[1]);
        end
        for (int c = 0; c < 10; c++) step(1'b0, 1'b0, 1'b0, 1'b0);
        $display("scenario random checks=%0d failures=%0d", checks, failures);

        // Reset during WAIT of a req1 write aborts it without a ready.
        for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 1'b1, 1'b1);
        check("abort_busy_before", busy, 1'b1);
        do_reset();
        for (int c = 0; c < 12; c++) step(1'b0, 1'b0, 1'b0, 1'b0);
        $display("scenario reset_abort checks=%0d failures=%0d", checks, failures);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
